dmem_responder: RTL

Multi-cycle data-memory responder for the pipeline2.0 core. It sits on the processor's load/store port and answers requests through a req/ready handshake, with a parameterised wait-state latency. A request carries a byte address, write data and a write flag. The block performs the word access and returns read data with a one-cycle MemReady pulse. This lets the core be verified against non-zero memory latency before a cache or bus bridge exists.

---
 rtl/dmem_responder.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Multi-cycle data-memory responder for the pipeline2.0 load/store port.
// One request at a time is accepted from IDLE. The block waits a
// parameterised number of cycles, commits the word access on the edge that
// enters DONE, and then pulses MemReady for one cycle.
//
// Parameters
//   DEPTH    storage size in 32-bit words (power of two, >= 4)
//   LATENCY  cycles from accept edge to MemReady (1..15)
//
// Configuration macro
//   DMEM_ALIGN_CHECK_EN  when defined, an access whose Address[1:0] != 0 is
//                        aborted at commit: no memory write, ReadData <= 0,
//                        MemError = 1 alongside MemReady. When undefined the
//                        low address bits are ignored and MemError is tied 0.
//
// Ports
//   clk        system clock, all state on the rising edge
//   reset      synchronous, active-high reset
//   MemReq     request valid, sampled only in IDLE
//   MemWrite   1 = store, 0 = load, sampled with MemReq
//   Address    byte address; word index = Address[log2(DEPTH)+1:2]
//   WriteData  store data, sampled with MemReq
//   ReadData   registered load result, held until the next load
//   MemReady   one-cycle completion pulse (state DONE)
//   MemBusy    transaction in flight (WAIT or DONE)
//   MemError   misaligned-access flag, valid with MemReady
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReq,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        MemReady,
  output logic        MemBusy,
  output logic        MemError
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            accept;
  logic            commit;

  // Request fields captured on the accept edge.
  logic            we_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;

  // Operands seen by the commit logic. With LATENCY=1 the commit happens on
  // the accept edge itself, before the capture registers hold the request,
  // so in IDLE the live inputs are used instead.
  logic            op_we;
  logic [AW-1:0]   op_idx;
  logic [31:0]     op_wdata;
  logic            misalign;

  logic [31:0]     mem [DEPTH];
  logic [31:0]     rdata_q;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every always_ff reads the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that left
    // one unassigned would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (MemReq) begin
          accept = 1'b1;
          cnt_d  = 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_d = S_DONE;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_DONE;
          commit  = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request capture (pure datapath; its content only matters after accept)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= MemWrite;
      idx_q   <= Address[AW+1:2];
      wdata_q <= WriteData;
    end
  end

  assign op_we    = (state_q == S_IDLE) ? MemWrite         : we_q;
  assign op_idx   = (state_q == S_IDLE) ? Address[AW+1:2]  : idx_q;
  assign op_wdata = (state_q == S_IDLE) ? WriteData        : wdata_q;

`ifdef DMEM_ALIGN_CHECK_EN
  logic [1:0] off_q;
  logic       err_q;

  always_ff @(posedge clk) begin
    if (accept) begin
      off_q <= Address[1:0];
    end
  end

  assign misalign = ((state_q == S_IDLE) ? Address[1:0] : off_q) != 2'b00;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (commit) begin
      err_q <= misalign;
    end
  end

  assign MemError = MemReady & err_q;

  // Upper address bits select nothing: accesses wrap modulo DEPTH words.
  logic unused_addr;
  assign unused_addr = ^Address[31:AW+2];
`else
  assign misalign = 1'b0;
  assign MemError = 1'b0;

  // Byte offset and upper address bits are ignored in this build.
  logic unused_addr;
  assign unused_addr = ^{Address[31:AW+2], Address[1:0]};
`endif

  // ---------------------------------------------------------------------------
  // Storage. Writes are suppressed while reset is high so a pending store
  // that would commit on a reset edge is discarded.
  // ---------------------------------------------------------------------------
  // NOTE: the memory array has no reset; clearing it would need a per-word
  // reset network and contents are deliberately preserved across reset.
  always_ff @(posedge clk) begin
    if (!reset && commit && op_we && !misalign) begin
      mem[op_idx] <= op_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Read data: updated only by loads and by aborted accesses; stores and idle
  // cycles leave the last load value in place.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (commit) begin
      if (misalign) begin
        rdata_q <= '0;
      end else if (!op_we) begin
        rdata_q <= mem[op_idx];
      end
    end
  end

  assign ReadData = rdata_q;
  assign MemReady = (state_q == S_DONE);
  assign MemBusy  = (state_q != S_IDLE);

endmodule
